axil_sram_responder: RTL and testbench

AXIL_SRAM_RESPONDER -- requirements
Module: axil_sram_responder

---
 rtl/axil_sram_responder.sv | 211 +++++++++++++++++++++
 tb/tb_axil_sram_responder.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_sram_responder.sv
// AXI4-Lite slave fronting a word-addressed SRAM with configurable read
// and write latencies; read and write paths run as independent FSMs.
module axil_sram_responder #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          RD_LAT      = 2,
    parameter int          WR_LAT      = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int          IW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

    function automatic logic in_range(input logic [31:0] a);
        logic [31:0] off;
        off = a - ADDR_BASE;
        return off < SPAN;
    endfunction

    function automatic logic [IW-1:0] word_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - ADDR_BASE;
        return IW'(off >> 2);
    endfunction

    logic [31:0] mem [DEPTH_WORDS];

    r_state_t    r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_src;
    logic        r_ok;
    logic [31:0] r_word;

    w_state_t    w_state;
    logic [3:0]  w_cnt;
    logic        aw_got;
    logic        w_got;
    logic [31:0] w_addr;
    logic [31:0] w_data;
    logic [3:0]  w_strb;

    logic        aw_take;
    logic        w_take;
    logic        both;
    logic [31:0] c_addr;
    logic [31:0] c_data;
    logic [3:0]  c_strb;
    logic        c_ok;
    logic        wr_commit;

    // With zero read latency the sample happens on the accept edge itself.
    assign r_src  = (RD_LAT == 0) ? araddr : r_addr;
    assign r_ok   = in_range(r_src);
    assign r_word = r_ok ? mem[word_idx(r_src)] : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= R_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 32'h0;
            arready <= 1'b1;
            rvalid  <= 1'b0;
            rdata   <= 32'h0;
            rresp   <= 2'b00;
        end else begin
            unique case (r_state)
                R_IDLE: begin
                    if (arvalid) begin
                        r_addr  <= araddr;
                        r_cnt   <= 4'(RD_LAT);
                        arready <= 1'b0;
                        if (RD_LAT == 0) begin
                            rdata   <= r_word;
                            rresp   <= r_ok ? 2'b00 : 2'b11;
                            rvalid  <= 1'b1;
                            r_state <= R_RESP;
                        end else begin
                            r_state <= R_WAIT;
                        end
                    end
                end
                R_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        rdata   <= r_word;
                        rresp   <= r_ok ? 2'b00 : 2'b11;
                        rvalid  <= 1'b1;
                        r_state <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        rvalid  <= 1'b0;
                        arready <= 1'b1;
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Same-cycle captures bypass the holding registers.
    assign aw_take = awvalid && awready && (w_state == W_IDLE);
    assign w_take  = wvalid && wready && (w_state == W_IDLE);
    assign both    = (aw_got || aw_take) && (w_got || w_take);
    assign c_addr  = aw_take ? awaddr : w_addr;
    assign c_data  = w_take ? wdata : w_data;
    assign c_strb  = w_take ? wstrb : w_strb;
    assign c_ok    = in_range(c_addr);

    assign wr_commit = !rst &&
        (((w_state == W_WAIT) && (w_cnt == 4'd0)) ||
         ((WR_LAT == 0) && (w_state == W_IDLE) && both));

    always_ff @(posedge clk) begin
        if (wr_commit && c_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (c_strb[i]) begin
                    mem[word_idx(c_addr)][8*i +: 8] <= c_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state <= W_IDLE;
            w_cnt   <= 4'd0;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            w_addr  <= 32'h0;
            w_data  <= 32'h0;
            w_strb  <= 4'h0;
            awready <= 1'b1;
            wready  <= 1'b1;
            bvalid  <= 1'b0;
            bresp   <= 2'b00;
        end else begin
            unique case (w_state)
                W_IDLE: begin
                    if (aw_take) begin
                        w_addr  <= awaddr;
                        aw_got  <= 1'b1;
                        awready <= 1'b0;
                    end
                    if (w_take) begin
                        w_data <= wdata;
                        w_strb <= wstrb;
                        w_got  <= 1'b1;
                        wready <= 1'b0;
                    end
                    if (both) begin
                        w_cnt <= 4'(WR_LAT);
                        if (WR_LAT == 0) begin
                            bvalid  <= 1'b1;
                            bresp   <= c_ok ? 2'b00 : 2'b11;
                            w_state <= W_RESP;
                        end else begin
                            w_state <= W_WAIT;
                        end
                    end
                end
                W_WAIT: begin
                    if (w_cnt == 4'd0) begin
                        bvalid  <= 1'b1;
                        bresp   <= c_ok ? 2'b00 : 2'b11;
                        w_state <= W_RESP;
                    end else begin
                        w_cnt <= w_cnt - 4'd1;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        aw_got  <= 1'b0;
                        w_got   <= 1'b0;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_sram_responder.sv
// Randomized scoreboard bench for axil_sram_responder with an
// associative-array memory model and directed latency/hazard/reset cases.
module tb_axil_sram_responder;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;

    axil_sram_responder #(
        .ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .RD_LAT(2), .WR_LAT(1)
    ) dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        bit          chk;
    } rexp_t;

    rexp_t       rd_q[$];
    logic [1:0]  wr_q[$];
    logic [31:0] mdl[int];
    int compared = 0;
    int mismatched = 0;
    int lat_r, lat_w;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        compared++;
        mismatched++;
        $display("FAIL %s: got timeout expected handshake", nm);
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(BASE);
        return off >= 0 && off < 4 * DEPTH;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((longint'(a) - longint'(BASE)) / 4);
    endfunction

    task automatic push_rd(input logic [31:0] a);
        rexp_t e;
        if (!in_rng(a)) begin
            e.data = 32'h0; e.resp = 2'b11; e.chk = 1;
        end else if (mdl.exists(widx(a))) begin
            e.data = mdl[widx(a)]; e.resp = 2'b00; e.chk = 1;
        end else begin
            e.data = 32'h0; e.resp = 2'b00; e.chk = 0;
        end
        rd_q.push_back(e);
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
        logic [31:0] v;
        int k;
        if (!in_rng(a)) begin
            wr_q.push_back(2'b11);
            return;
        end
        wr_q.push_back(2'b00);
        k = widx(a);
        if (mdl.exists(k)) begin
            v = mdl[k];
            for (int i = 0; i < 4; i++)
                if (s[i]) v[8*i +: 8] = d[8*i +: 8];
            mdl[k] = v;
        end else if (s == 4'hF) begin
            mdl[k] = d;
        end
    endtask

    rexp_t      mon_r;
    logic [1:0] mon_b;

    always @(negedge clk) begin
        if (!rst && rvalid && rready) begin
            if (rd_q.size() == 0) begin
                tmo("r_unexpected");
            end else begin
                mon_r = rd_q.pop_front();
                chk("rresp", 32'(rresp), 32'(mon_r.resp));
                if (mon_r.chk) chk("rdata", rdata, mon_r.data);
            end
        end
        if (!rst && bvalid && bready) begin
            if (wr_q.size() == 0) begin
                tmo("b_unexpected");
            end else begin
                mon_b = wr_q.pop_front();
                chk("bresp", 32'(bresp), 32'(mon_b));
            end
        end
    end

    task automatic rd(input logic [31:0] a, input int stall, input bit push,
                      output int lat);
        int n;
        bit ok;
        if (push) push_rd(a);
        araddr = a;
        arvalid = 1'b1;
        n = 0;
        ok = 0;
        lat = -1;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (arready) ok = 1;
            else n++;
        end
        if (!ok) begin
            arvalid = 1'b0;
            tmo("ar_accept");
            return;
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        lat = 0;
        while (!rvalid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!rvalid) begin
            tmo("rvalid_wait");
            return;
        end
        repeat (stall) begin
            chk("rvalid_stall", 32'(rvalid), 32'd1);
            if (rd_q.size() > 0 && rd_q[0].chk)
                chk("rdata_stall", rdata, rd_q[0].data);
            @(posedge clk); #1;
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        chk("rvalid_drop", 32'(rvalid), 32'd0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int mode, input int bdly,
                      input bit push, output int lat);
        bit ga, gw, ca, cw;
        int n;
        if (push) push_wr(a, d, s);
        awaddr = a;
        wdata = d;
        wstrb = s;
        awvalid = (mode != 2);
        wvalid = (mode != 1);
        ga = 0;
        gw = 0;
        n = 0;
        lat = -1;
        while (!(ga && gw) && n < 50) begin
            @(negedge clk);
            ca = awvalid && awready;
            cw = wvalid && wready;
            @(posedge clk); #1;
            if (ca) begin
                awvalid = 1'b0; ga = 1;
                if (!gw) wvalid = 1'b1;
            end
            if (cw) begin
                wvalid = 1'b0; gw = 1;
                if (!ga) awvalid = 1'b1;
            end
            n++;
        end
        if (!(ga && gw)) begin
            awvalid = 1'b0;
            wvalid = 1'b0;
            tmo("aw_w_accept");
            return;
        end
        lat = 0;
        while (!bvalid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bvalid) begin
            tmo("bvalid_wait");
            return;
        end
        repeat (bdly) begin
            @(posedge clk); #1;
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        chk("bvalid_drop", 32'(bvalid), 32'd0);
    endtask

    function automatic logic [31:0] rnd_addr();
        case ($urandom_range(0, 9))
            0: return BASE - 32'(4 * $urandom_range(1, 4));
            1: return BASE + 32'(4 * DEPTH + 4 * $urandom_range(0, 3));
            2: return BASE + 32'(4 * DEPTH - 4) + 32'($urandom_range(0, 3));
            default: return BASE + 32'(4 * $urandom_range(0, 15))
                                 + 32'($urandom_range(0, 3));
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_rresp", 32'(rresp), 32'd0);
        chk("rst_bresp", 32'(bresp), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_arready", 32'(arready), 32'd1);
        chk("post_awready", 32'(awready), 32'd1);
        chk("post_wready", 32'(wready), 32'd1);

        wr(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 1, 0, 1, lat_w);
        chk("wr_lat_aw_first", 32'(lat_w), 32'd2);
        rd(BASE + 32'h10, 0, 1, lat_r);
        chk("rd_lat", 32'(lat_r), 32'd2);
        rd(BASE + 32'h10, 3, 1, lat_r);
        chk("rd_lat_stall", 32'(lat_r), 32'd2);

        wr(BASE + 32'h10, 32'h1122_3344, 4'b0011, 0, 1, 1, lat_w);
        chk("wr_lat_same", 32'(lat_w), 32'd2);
        rd(BASE + 32'h10, 0, 1, lat_r);
        wr(BASE + 32'h10, 32'h0000_00AA, 4'b0001, 2, 2, 1, lat_w);
        chk("wr_lat_w_first", 32'(lat_w), 32'd2);
        rd(BASE + 32'h10, 1, 1, lat_r);

        rd(32'h7FFF_FFFC, 0, 1, lat_r);
        wr(32'h8000_1000, 32'h1234_5678, 4'hF, 0, 0, 1, lat_w);
        rd(BASE + 32'h10, 0, 1, lat_r);
        wr(BASE + 32'hFFC, 32'hCAFE_F00D, 4'hF, 0, 0, 1, lat_w);
        rd(BASE + 32'hFFF, 0, 1, lat_r);

        push_rd(BASE + 32'h10);
        push_wr(BASE + 32'h10, 32'h5566_7788, 4'hF);
        fork
            rd(BASE + 32'h10, 0, 0, lat_r);
            wr(BASE + 32'h10, 32'h5566_7788, 4'hF, 0, 0, 0, lat_w);
        join
        chk("hazard_rd_lat", 32'(lat_r), 32'd2);
        chk("hazard_wr_lat", 32'(lat_w), 32'd2);
        rd(BASE + 32'h10, 0, 1, lat_r);

        araddr = BASE + 32'h10;
        arvalid = 1'b1;
        awaddr = BASE + 32'h10;
        wdata = 32'h0BAD_F00D;
        wstrb = 4'hF;
        awvalid = 1'b1;
        wvalid = 1'b1;
        @(negedge clk);
        chk("abort_arready", 32'(arready), 32'd1);
        chk("abort_awready", 32'(awready), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        awvalid = 1'b0;
        wvalid = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_rvalid", 32'(rvalid), 32'd0);
        chk("abort_bvalid", 32'(bvalid), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_arready_after", 32'(arready), 32'd1);
        chk("abort_awready_after", 32'(awready), 32'd1);
        chk("abort_wready_after", 32'(wready), 32'd1);
        chk("abort_rvalid_after", 32'(rvalid), 32'd0);
        chk("abort_bvalid_after", 32'(bvalid), 32'd0);
        rd(BASE + 32'h10, 0, 1, lat_r);

        repeat (120) begin
            a = rnd_addr();
            if ($urandom_range(0, 1) == 0) begin
                rd(a, $urandom_range(0, 3), 1, lat_r);
                chk("rnd_rd_lat", 32'(lat_r), 32'd2);
            end else begin
                wr(a, $urandom, 4'($urandom_range(0, 15)),
                   $urandom_range(0, 2), $urandom_range(0, 3), 1, lat_w);
                chk("rnd_wr_lat", 32'(lat_w), 32'd2);
            end
        end

        repeat (5) @(posedge clk);
        #1;
        chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
        chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
